// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

   localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEADBEEF;
   localparam int STREAK_W = 4;

   // Shifting left by one drops bit 31; shifting right by three drops the byte offset.
   function automatic logic [28:0] word_addr(input logic [31:0] byte_addr);
      return 29'((byte_addr << 1) >> 3);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Fixed-priority grant decision favouring the data port, with a streak
// counter that forces a fetch grant after MAX_D_STREAK back-to-back data grants.
module mem_arb_select import mem_arb_pkg::*; #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_en,
   output logic grant_i,
   output logic grant_d
);

   logic [STREAK_W-1:0] streak;

   always_comb begin
      grant_d = grant_en && d_req && ((streak < STREAK_W'(MAX_D_STREAK)) || !i_req);
      grant_i = grant_en && i_req && !grant_d;
   end

   // Streak only grows while fetch is actually waiting behind data.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (grant_d) begin
         streak <= i_req ? streak + 1'b1 : '0;
      end else if (grant_i) begin
         streak <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access.
// Optional performance counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int unsigned MAX_D_STREAK   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic [28:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read_req,
   output logic        mem_write_req,
   input  logic        mem_read_valid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_write_ready,
   input  logic        mem_read_ready,
   input  logic        mem_stall
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_stall_cycles,
   output logic [15:0] perf_timeouts
`endif
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state;
   arb_owner_t       owner;
   logic [TMO_W-1:0] tmo_cnt;
   logic             grant_i;
   logic             grant_d;
   logic             rd_done;
   logic             tmo_hit;
   logic [31:0]      rd_data;

   mem_arb_select #(
      .MAX_D_STREAK(MAX_D_STREAK)
   ) u_select (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .d_req   (d_req),
      .grant_en(state == IDLE),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   // Memory handshakes drop in the same cycle a stall appears.
   always_comb begin
      mem_read_req  = (state == RD) && mem_read_ready && !mem_stall;
      mem_write_req = (state == WR) && mem_write_ready && !mem_stall;
      rd_done       = (state == RD) && mem_read_valid && !mem_stall;
      tmo_hit       = (state == RD) && !rd_done && (tmo_cnt == TMO_LAST);
      rd_data       = rd_done ? mem_rdata : ARB_TIMEOUT_DATA;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_I;
         tmo_cnt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         err       <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (grant_d) begin
                  owner     <= OWN_D;
                  mem_addr  <= word_addr(d_addr);
                  mem_wdata <= d_wdata;
                  d_gnt     <= 1'b1;
                  state     <= d_we ? WR : RD;
               end else if (grant_i) begin
                  owner    <= OWN_I;
                  mem_addr <= word_addr(i_addr);
                  i_gnt    <= 1'b1;
                  state    <= RD;
               end
            end
            RD: begin
               if (rd_done || tmo_hit) begin
                  if (owner == OWN_D) begin
                     d_rdata  <= rd_data;
                     d_rvalid <= 1'b1;
                  end else begin
                     i_rdata  <= rd_data;
                     i_rvalid <= 1'b1;
                  end
                  err     <= tmo_hit;
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WR: begin
               if (mem_write_req) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_grants     <= '0;
         perf_d_grants     <= '0;
         perf_stall_cycles <= '0;
         perf_timeouts     <= '0;
      end else begin
         if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
         if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
         if ((state != IDLE) && mem_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (tmo_hit) perf_timeouts <= perf_timeouts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one instance with the
// default timeout and one with a 16-cycle timeout, sharing all inputs.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        mem_read_valid;
   logic [31:0] mem_rdata;
   logic        mem_write_ready;
   logic        mem_read_ready;
   logic        mem_stall;

   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, err, mem_read_req, mem_write_req;
   logic [31:0] i_rdata, d_rdata, mem_wdata;
   logic [28:0] mem_addr;

   logic        t_i_gnt, t_i_rvalid, t_d_gnt, t_d_rvalid, t_err, t_mem_read_req, t_mem_write_req;
   logic [31:0] t_i_rdata, t_d_rdata, t_mem_wdata;
   logic [28:0] t_mem_addr;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_stall_cycles;
   logic [15:0] perf_timeouts;
   logic [31:0] t_perf_i_grants, t_perf_d_grants, t_perf_stall_cycles;
   logic [15:0] t_perf_timeouts;
`endif

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(1024)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_req(mem_read_req),
      .mem_write_req(mem_write_req), .mem_read_valid(mem_read_valid), .mem_rdata(mem_rdata),
      .mem_write_ready(mem_write_ready), .mem_read_ready(mem_read_ready), .mem_stall(mem_stall)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_stall_cycles(perf_stall_cycles), .perf_timeouts(perf_timeouts)
`endif
   );

   mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(16)) dut_tmo (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(t_i_gnt), .i_rvalid(t_i_rvalid), .i_rdata(t_i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(t_d_gnt), .d_rvalid(t_d_rvalid), .d_rdata(t_d_rdata), .err(t_err),
      .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_read_req(t_mem_read_req),
      .mem_write_req(t_mem_write_req), .mem_read_valid(mem_read_valid), .mem_rdata(mem_rdata),
      .mem_write_ready(mem_write_ready), .mem_read_ready(mem_read_ready), .mem_stall(mem_stall)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_i_grants(t_perf_i_grants), .perf_d_grants(t_perf_d_grants),
      .perf_stall_cycles(t_perf_stall_cycles), .perf_timeouts(t_perf_timeouts)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
      i_req   = ireq;
      i_addr  = iaddr;
      d_req   = dreq;
      d_we    = dwe;
      d_addr  = daddr;
      d_wdata = dwdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   logic [9:0] grant_seq;
   int n_grants;
   int bad;
   int rv_count;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_read_valid  = 1'b0;
      mem_rdata       = 32'h0;
      mem_write_ready = 1'b1;
      mem_read_ready  = 1'b1;
      mem_stall       = 1'b0;
      tick();
      tick();
      sample();
      checkOutput("rst_gnt",      {30'h0, i_gnt, d_gnt}, 32'h0);
      checkOutput("rst_rvalid",   {29'h0, i_rvalid, d_rvalid, err}, 32'h0);
      checkOutput("rst_mem_req",  {30'h0, mem_read_req, mem_write_req}, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_rdata",    i_rdata | d_rdata | mem_wdata, 32'h0);

      // Lone fetch: request in cycle 0, read data two cycles after the grant
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("fetch_gnt_c0", i_gnt, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("fetch_gnt_c1", i_gnt, 1'b1);
      checkOutput("fetch_rdreq_c1", mem_read_req, 1'b1);
      checkOutput("fetch_mem_addr", mem_addr, 32'h40);
      checkOutput("fetch_no_dgnt", d_gnt, 1'b0);
      tick();
      sample();
      checkOutput("fetch_gnt_pulse", i_gnt, 1'b0);
      checkOutput("fetch_rdreq_held", mem_read_req, 1'b1);
      tick();
      mem_read_valid = 1'b1;
      mem_rdata      = 32'h0013_0313;
      sample();
      checkOutput("fetch_rvalid_early", i_rvalid, 1'b0);
      tick();
      mem_read_valid = 1'b0;
      sample();
      checkOutput("fetch_rvalid", i_rvalid, 1'b1);
      checkOutput("fetch_rdata", i_rdata, 32'h0013_0313);
      checkOutput("fetch_err", err, 1'b0);
      checkOutput("fetch_d_quiet", {31'h0, d_rvalid} | d_rdata, 32'h0);
      checkOutput("fetch_rdreq_done", mem_read_req, 1'b0);
      tick();
      sample();
      checkOutput("fetch_rvalid_pulse", i_rvalid, 1'b0);
      checkOutput("fetch_rdata_hold", i_rdata, 32'h0013_0313);

      // Data write with memory ready
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
      sample();
      checkOutput("wr_req_c0", mem_write_req, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("wr_dgnt", d_gnt, 1'b1);
      checkOutput("wr_req", mem_write_req, 1'b1);
      checkOutput("wr_mem_addr", mem_addr, 32'h800);
      checkOutput("wr_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      tick();
      sample();
      checkOutput("wr_req_single", {30'h0, mem_write_req, d_gnt}, 32'h0);
      checkOutput("wr_no_rvalid", d_rvalid, 1'b0);

      // Data write held off by mem_write_ready
      tick();
      mem_write_ready = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2004, 32'h1111_2222);
      sample();
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("wrwait_dgnt", d_gnt, 1'b1);
      checkOutput("wrwait_req_low", mem_write_req, 1'b0);
      tick();
      mem_write_ready = 1'b1;
      sample();
      checkOutput("wrwait_req", mem_write_req, 1'b1);
      checkOutput("wrwait_addr", mem_addr, 32'h801);
      checkOutput("wrwait_wdata", mem_wdata, 32'h1111_2222);
      tick();
      sample();
      checkOutput("wrwait_done", mem_write_req, 1'b0);

      // Starvation: both ports requesting continuously
      tick();
      mem_read_valid = 1'b1;
      mem_rdata      = 32'h5555_AAAA;
      applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0080, 32'h1);
      grant_seq = '0;
      n_grants  = 0;
      for (int c = 0; c < 200 && n_grants < 10; c++) begin
         tick();
         sample();
         if (d_gnt) begin
            grant_seq = {grant_seq[8:0], 1'b1};
            n_grants++;
         end
         if (i_gnt) begin
            grant_seq = {grant_seq[8:0], 1'b0};
            n_grants++;
         end
      end
      checkOutput("starve_grant_count", n_grants, 10);
      checkOutput("starve_order", {22'h0, grant_seq}, {22'h0, 10'b11110_11110});
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      mem_read_valid = 1'b0;
      tick();
      tick();

      // Stall for 20 cycles in the middle of a fetch read
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("stall_gnt", i_gnt, 1'b1);
      checkOutput("stall_rdreq_pre", mem_read_req, 1'b1);
      bad      = 0;
      rv_count = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         mem_stall      = 1'b1;
         mem_read_valid = (c == 19);
         mem_rdata      = 32'hBAD0_BAD0;
         sample();
         if (mem_read_req !== 1'b0) bad++;
         if (mem_addr !== 29'h400) bad++;
         if (i_rvalid) rv_count++;
      end
      checkOutput("stall_req_low_addr_stable", bad, 0);
      tick();
      mem_stall      = 1'b0;
      mem_read_valid = 1'b0;
      sample();
      checkOutput("stall_rdreq_reassert", mem_read_req, 1'b1);
      checkOutput("stall_addr_after", mem_addr, 32'h400);
      if (i_rvalid) rv_count++;
      tick();
      mem_read_valid = 1'b1;
      mem_rdata      = 32'h1234_5678;
      sample();
      if (i_rvalid) rv_count++;
      tick();
      mem_read_valid = 1'b0;
      sample();
      checkOutput("stall_rvalid", i_rvalid, 1'b1);
      checkOutput("stall_rdata", i_rdata, 32'h1234_5678);
      if (i_rvalid) rv_count++;
      for (int c = 0; c < 3; c++) begin
         tick();
         sample();
         if (i_rvalid) rv_count++;
      end
      checkOutput("stall_one_rvalid", rv_count, 1);

      // Timeout on the 16-cycle instance: data read that never returns
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("tmo_dgnt", t_d_gnt, 1'b1);
      checkOutput("tmo_rdreq_start", t_mem_read_req, 1'b1);
      bad = 0;
      for (int c = 2; c <= 16; c++) begin
         tick();
         sample();
         if (t_d_rvalid || t_err) bad++;
      end
      checkOutput("tmo_no_early_pulse", bad, 0);
      checkOutput("tmo_rdreq_last", t_mem_read_req, 1'b1);
      tick();
      sample();
      checkOutput("tmo_rvalid", t_d_rvalid, 1'b1);
      checkOutput("tmo_err", t_err, 1'b1);
      checkOutput("tmo_rdata", t_d_rdata, 32'hDEAD_BEEF);
      checkOutput("tmo_rdreq_drop", t_mem_read_req, 1'b0);
      checkOutput("tmo_no_irvalid", t_i_rvalid, 1'b0);
      tick();
      sample();
      checkOutput("tmo_pulse_end", {30'h0, t_d_rvalid, t_err}, 32'h0);
      checkOutput("tmo_rdata_hold", t_d_rdata, 32'hDEAD_BEEF);

      // Reset while the default instance still has that read outstanding
      checkOutput("rstmid_pre_rd", mem_read_req, 1'b1);
      tick();
      rst            = 1'b1;
      mem_read_valid = 1'b1;
      mem_rdata      = 32'hFFFF_0000;
      tick();
      rst            = 1'b0;
      mem_read_valid = 1'b0;
      sample();
      checkOutput("rstmid_outputs", {27'h0, d_rvalid, err, mem_read_req, d_gnt, i_gnt}, 32'h0);
      checkOutput("rstmid_addr", mem_addr, 32'h0);
      checkOutput("rstmid_rdata", d_rdata, 32'h0);
      tick();
      applyStimulus(1'b1, 32'h8000_0103, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("rstmid_no_pulse", {30'h0, d_rvalid, i_rvalid}, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("rstmid_fresh_gnt", i_gnt, 1'b1);
      checkOutput("rstmid_fresh_addr", mem_addr, 32'h40);
      tick();
      mem_read_valid = 1'b1;
      mem_rdata      = 32'hA5A5_0001;
      sample();
      tick();
      mem_read_valid = 1'b0;
      sample();
      checkOutput("rstmid_fresh_rvalid", i_rvalid, 1'b1);
      checkOutput("rstmid_fresh_rdata", i_rdata, 32'hA5A5_0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
